issue_scoreboard: RTL and testbench

- Issue stage directly downstream of the frontend issue queue.
- Pops decoded entries from the queue and tracks in-flight destination registers in a 31-entry busy scoreboard (x1..x31).
- Stalls on RAW/WAW hazards and hands entries to the execute stage through a registered valid/ready output slot.
- Clears busy bits on writeback and kills the slot on a branch flush.

---
 rtl/issue_scoreboard.sv | 114 +++++++++++
 tb/tb_issue_scoreboard.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue stage: pops the frontend issue queue, tracks in-flight destination
// registers in a busy scoreboard (x1..x31), stalls on RAW/WAW hazards and
// hands entries to execute through a registered valid/ready slot.
// Optional build macro ISSUE_WB_BYPASS_EN: when defined, a writeback in the
// current cycle unblocks a dependent head in that same cycle; otherwise the
// registered busy bits are used and a one-cycle bubble follows writeback.
module issue_scoreboard #(
  parameter int ISSUE_Q_WIDTH = 123,
  parameter int ADDR_WIDTH    = 32,
  parameter int REG_NUM       = 32,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     issue_q_rok,
  input  logic [ISSUE_Q_WIDTH-1:0] issue_q_rdata,
  output logic                     issue_q_ren,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [ISSUE_Q_WIDTH-1:0] ex_data,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic                     flush,
  output logic                     hazard_stall,
  output logic [CNT_WIDTH-1:0]     stall_cnt
);

  // Register-field offsets follow taken + nxt_pc + cur_pc at the bottom.
  localparam int RD_WEN_BIT = 2 * ADDR_WIDTH + 1;
  localparam int RD_LSB     = RD_WEN_BIT + 1;
  localparam int RS2_LSB    = RD_LSB + 5;
  localparam int RS1_LSB    = RS2_LSB + 5;

  logic [REG_NUM-1:0]       busy_q, busy_d, busy_chk;
  logic                     ex_valid_q, ex_valid_d;
  logic [ISSUE_Q_WIDTH-1:0] ex_data_q, ex_data_d;
  logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;

  logic       head_wen, slot_wen, hazard, slot_free;
  logic [4:0] head_rd, head_rs1, head_rs2, slot_rd;

  assign head_wen = issue_q_rdata[RD_WEN_BIT];
  assign head_rd  = issue_q_rdata[RD_LSB +: 5];
  assign head_rs2 = issue_q_rdata[RS2_LSB +: 5];
  assign head_rs1 = issue_q_rdata[RS1_LSB +: 5];
  assign slot_wen = ex_data_q[RD_WEN_BIT];
  assign slot_rd  = ex_data_q[RD_LSB +: 5];

  // Busy view used for the hazard check (optionally bypassing writeback).
  always_comb begin
    busy_chk = busy_q;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_valid) busy_chk[wb_rd] = 1'b0;
`else
`endif
  end

  // Conservative RAW/WAW hazard detect and dispatch handshake.
  always_comb begin
    hazard = ((head_rs1 != 5'd0) && busy_chk[head_rs1]) ||
             ((head_rs2 != 5'd0) && busy_chk[head_rs2]) ||
             (head_wen && (head_rd != 5'd0) && busy_chk[head_rd]);
    slot_free    = !ex_valid_q || ex_ready;
    issue_q_ren  = issue_q_rok && !hazard && slot_free && !flush && !RST;
    hazard_stall = issue_q_rok && hazard && !flush && !RST;
  end

  // Next-state for slot, scoreboard and stall counter; flush dominates.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_data_d   = ex_data_q;
    busy_d      = busy_q;
    stall_cnt_d = stall_cnt_q;

    if (hazard_stall && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    if (wb_valid && (wb_rd != 5'd0)) busy_d[wb_rd] = 1'b0;

    if (flush) begin
      // The killed slot never reaches writeback, so release its destination.
      if (ex_valid_q && slot_wen && (slot_rd != 5'd0)) busy_d[slot_rd] = 1'b0;
      ex_valid_d = 1'b0;
    end else if (issue_q_ren) begin
      ex_valid_d = 1'b1;
      ex_data_d  = issue_q_rdata;
      if (head_wen && (head_rd != 5'd0)) busy_d[head_rd] = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end

    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid_q  <= 1'b0;
      ex_data_q   <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_data_q   <= ex_data_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_data   = ex_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed table, corner sequences and random
// stimulus compared against a scoreboard-level reference model.
module tb_issue_scoreboard;

  localparam int W  = 123;
  localparam int CW = 4;

  logic          CLK, RST, issue_q_rok, issue_q_ren, ex_valid, ex_ready;
  logic [W-1:0]  issue_q_rdata, ex_data;
  logic          wb_valid, flush, hazard_stall;
  logic [4:0]    wb_rd;
  logic [CW-1:0] stall_cnt;

  issue_scoreboard #(.ISSUE_Q_WIDTH(W), .ADDR_WIDTH(32), .REG_NUM(32), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .issue_q_rok(issue_q_rok), .issue_q_rdata(issue_q_rdata),
    .issue_q_ren(issue_q_ren), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data(ex_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .hazard_stall(hazard_stall),
    .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit           busy_m [32];
  bit           v_m;
  logic [W-1:0] d_m;
  int           cnt_m;

  logic         got_ren, got_hs, got_valid;
  logic [W-1:0] got_data;
  logic [CW-1:0] got_cnt;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int rd, input int rs1, input int rs2,
                                      input bit wen, input int tag);
    logic [W-1:0] e;
    e = '0;
    e[0]      = tag[0];
    e[32:1]   = 32'h1000 + tag;
    e[64:33]  = 32'h0FFC + tag;
    e[65]     = wen;
    e[70:66]  = rd[4:0];
    e[75:71]  = rs2[4:0];
    e[80:76]  = rs1[4:0];
    e[112:81] = tag;
    e[116:113] = tag[3:0];
    return e;
  endfunction

  // One clock of stimulus: drive at negedge, sample and compare, then advance the model.
  task automatic cycle(input logic r, input logic rok, input logic [W-1:0] e, input logic rdy,
                       input logic wbv, input logic [4:0] wbr, input logic fl, input bit chk);
    bit eff [32];
    bit haz, exp_ren, exp_hs;
    int rd, rs1, rs2;
    bit wen;
    @(negedge CLK);
    RST = r; issue_q_rok = rok; issue_q_rdata = e; ex_ready = rdy;
    wb_valid = wbv; wb_rd = wbr; flush = fl;
    #1;
    eff = busy_m;
`ifdef ISSUE_WB_BYPASS_EN
    if (wbv) eff[wbr] = 1'b0;
`endif
    rd = int'(e[70:66]); rs2 = int'(e[75:71]); rs1 = int'(e[80:76]); wen = e[65];
    haz = (rs1 != 0 && eff[rs1]) || (rs2 != 0 && eff[rs2]) || (wen && rd != 0 && eff[rd]);
    exp_ren = !r && rok && !haz && (!v_m || rdy) && !fl;
    exp_hs  = !r && rok && haz && !fl;
    got_ren = issue_q_ren; got_hs = hazard_stall; got_valid = ex_valid;
    got_data = ex_data; got_cnt = stall_cnt;
    if (chk) begin
      check("ren", 128'(issue_q_ren), 128'(exp_ren));
      check("hazard_stall", 128'(hazard_stall), 128'(exp_hs));
      check("ex_valid", 128'(ex_valid), 128'(v_m));
      if (v_m) check("ex_data", 128'(ex_data), 128'(d_m));
      check("stall_cnt", 128'(stall_cnt), 128'(cnt_m));
    end
    @(posedge CLK);
    if (r) begin
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      v_m = 1'b0; d_m = '0; cnt_m = 0;
    end else begin
      if (exp_hs && cnt_m < (1 << CW) - 1) cnt_m++;
      if (wbv && wbr != 0) busy_m[wbr] = 1'b0;
      if (fl) begin
        if (v_m && d_m[65] && d_m[70:66] != 0) busy_m[d_m[70:66]] = 1'b0;
        v_m = 1'b0;
      end else if (exp_ren) begin
        v_m = 1'b1; d_m = e;
        if (wen && rd != 0) busy_m[rd] = 1'b1;
      end else if (rdy) begin
        v_m = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic r, rok; int rd, rs1, rs2; logic wen, rdy, wbv; int wbr; logic fl;
    logic exp_ren, exp_hs, exp_valid;
  } vec_t;

  vec_t tbl [10];
  logic [W-1:0] e1, e2, head;
  int tag;

  initial begin
    RST = 1'b1; issue_q_rok = 1'b0; issue_q_rdata = '0; ex_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    v_m = 1'b0; d_m = '0; cnt_m = 0;

    //            r  rok rd rs1 rs2 wen rdy wbv wbr fl  ren hs valid
    tbl[0] = '{1'b1,1'b1, 5, 0, 0,1'b1,1'b1,1'b0, 0,1'b0, 1'b0,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b1, 5, 0, 0,1'b1,1'b1,1'b0, 0,1'b0, 1'b1,1'b0,1'b0};
    tbl[2] = '{1'b0,1'b1, 6, 5, 0,1'b1,1'b1,1'b0, 0,1'b0, 1'b0,1'b1,1'b1};
`ifdef ISSUE_WB_BYPASS_EN
    tbl[3] = '{1'b0,1'b1, 6, 5, 0,1'b1,1'b1,1'b1, 5,1'b0, 1'b1,1'b0,1'b0};
    tbl[4] = '{1'b0,1'b1, 6, 5, 0,1'b1,1'b1,1'b0, 0,1'b0, 1'b0,1'b1,1'b1};
    tbl[5] = '{1'b0,1'b0, 0, 0, 0,1'b0,1'b1,1'b1, 6,1'b0, 1'b0,1'b0,1'b0};
    tbl[9] = '{1'b0,1'b1, 3, 0, 0,1'b1,1'b1,1'b1, 3,1'b0, 1'b1,1'b0,1'b0};
`else
    tbl[3] = '{1'b0,1'b1, 6, 5, 0,1'b1,1'b1,1'b1, 5,1'b0, 1'b0,1'b1,1'b0};
    tbl[4] = '{1'b0,1'b1, 6, 5, 0,1'b1,1'b1,1'b0, 0,1'b0, 1'b1,1'b0,1'b0};
    tbl[5] = '{1'b0,1'b0, 0, 0, 0,1'b0,1'b1,1'b1, 6,1'b0, 1'b0,1'b0,1'b1};
    tbl[9] = '{1'b0,1'b1, 3, 0, 0,1'b1,1'b1,1'b1, 3,1'b0, 1'b0,1'b1,1'b0};
`endif
    tbl[6] = '{1'b0,1'b1, 0, 0, 0,1'b1,1'b1,1'b0, 0,1'b0, 1'b1,1'b0,1'b0};
    tbl[7] = '{1'b0,1'b1, 3, 0, 0,1'b1,1'b1,1'b0, 0,1'b0, 1'b1,1'b0,1'b1};
    tbl[8] = '{1'b0,1'b1, 3, 0, 0,1'b1,1'b1,1'b0, 0,1'b0, 1'b0,1'b1,1'b1};

    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    check("reset_ex_data", 128'(got_data), 128'd0);

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].rok, mk(tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].wen, 16 + i),
            tbl[i].rdy, tbl[i].wbv, 5'(tbl[i].wbr), tbl[i].fl, 1'b1);
      check($sformatf("tbl%0d_ren", i), 128'(got_ren), 128'(tbl[i].exp_ren));
      check($sformatf("tbl%0d_hs", i), 128'(got_hs), 128'(tbl[i].exp_hs));
      check($sformatf("tbl%0d_valid", i), 128'(got_valid), 128'(tbl[i].exp_valid));
    end

    // Backpressure: slot held for three cycles, then same-cycle reload.
    e1 = mk(10, 0, 0, 1'b1, 100);
    e2 = mk(11, 0, 0, 1'b1, 101);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, e1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, e2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("bp_ren_held", 128'(got_ren), 128'd0);
      check("bp_data_stable", 128'(got_data), 128'(e1));
    end
    cycle(1'b0, 1'b1, e2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    check("bp_reload_ren", 128'(got_ren), 128'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    check("bp_second_valid", 128'(got_valid), 128'd1);
    check("bp_second_data", 128'(got_data), 128'(e2));

    // Flush kills the slot holding rd=7 and releases busy[7].
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, mk(7, 0, 0, 1'b1, 200), 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, mk(8, 0, 0, 1'b1, 201), 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    check("flush_no_pop", 128'(got_ren), 128'd0);
    cycle(1'b0, 1'b1, mk(0, 7, 0, 1'b0, 202), 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    check("flush_valid_cleared", 128'(got_valid), 128'd0);
    check("flush_busy7_released", 128'(got_ren), 128'd1);

    // Stall counter saturation, then reset.
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, mk(9, 0, 0, 1'b1, 300), 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < (1 << CW) + 2; i++)
      cycle(1'b0, 1'b1, mk(12, 9, 0, 1'b1, 301), 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    check("sat_cnt", 128'(got_cnt), 128'd15);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    check("rst_cnt", 128'(got_cnt), 128'd0);
    check("rst_valid", 128'(got_valid), 128'd0);
    check("rst_data", 128'(got_data), 128'd0);

    // Random traffic against the model; head is held until popped.
    tag = 1000;
    head = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), tag);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), head,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0), 1'b1);
      if (got_ren) begin
        tag++;
        head = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom), tag);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
